// File: rtl/instrq_extra_feed_pkg.sv
// Shared definitions for the instruction-extra queue write path.
// Word width and the one-hot count/start encodings used by both the
// feeder and the queue itself.

`ifndef instrQExtra_width
`define instrQExtra_width 32
`endif

package instrq_extra_feed_pkg;

   localparam int IQE_DATA_W = `instrQExtra_width;

   // Number of set bits in a 4-slot valid mask (0..4).
   function automatic logic [2:0] iqe_popcount4(input logic [3:0] mask);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, mask[i]};
      end
      return n;
   endfunction

   // One-hot word count: bit n set means n words.
   function automatic logic [4:0] iqe_cnt_onehot(input logic [2:0] n);
      return 5'b00001 << n;
   endfunction

   // One-hot start slot for a tail-aligned bundle of n words: bit (4-n).
   function automatic logic [4:0] iqe_start_onehot(input logic [2:0] n);
      return 5'b10000 >> n;
   endfunction

endpackage

// File: rtl/iqe_compact.sv
// Mask-to-bundle packer: valid slots, taken in ascending index order, are
// tail-aligned so the last valid word always lands in slot 3. Unused
// slots are zero.

module iqe_compact
   import instrq_extra_feed_pkg::*;
#(
   parameter int DATA_WIDTH = `instrQExtra_width
) (
   input  logic [3:0]                 in_mask,
   input  logic [3:0][DATA_WIDTH-1:0] in_data,
   output logic [4:0]                 cnt,
   output logic [4:0]                 start,
   output logic [3:0][DATA_WIDTH-1:0] data
);

   logic [2:0] n;
   logic [2:0] k;
   logic [2:0] slot;

   // Walk the mask, placing the k-th valid word into slot 4-n+k.
   always_comb begin
      n    = iqe_popcount4(in_mask);
      k    = 3'd0;
      slot = 3'd0;
      data = '0;
      for (int i = 0; i < 4; i++) begin
         if (in_mask[i]) begin
            slot = 3'd4 - n + k;
            data[slot[1:0]] = in_data[i];
            k = k + 3'd1;
         end
      end
      cnt   = iqe_cnt_onehot(n);
      start = iqe_start_onehot(n);
   end

endmodule

// File: rtl/instrq_extra_feed.sv
// Write-side feeder for the two-thread instruction-extra queue.
// Compacts predecode bundles at the input and holds them in a 2-entry
// in-order buffer (OUT drives the queue, SKID absorbs one bundle of
// backpressure). Exceptions flush per-thread entries in the same cycle.

module instrq_extra_feed
   import instrq_extra_feed_pkg::*;
#(
   parameter int DATA_WIDTH = `instrQExtra_width
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  except,
   input  logic                  except_thread,
   input  logic                  in_vld,
   input  logic                  in_thread,
   input  logic [3:0]            in_mask,
   input  logic [DATA_WIDTH-1:0] in_data0,
   input  logic [DATA_WIDTH-1:0] in_data1,
   input  logic [DATA_WIDTH-1:0] in_data2,
   input  logic [DATA_WIDTH-1:0] in_data3,
   output logic                  in_rdy,
   input  logic                  fStall,
   input  logic                  doFStall,
   output logic                  write_wen,
   output logic                  write_thread,
   output logic [4:0]            write_cnt,
   output logic [4:0]            write_start,
   output logic [DATA_WIDTH-1:0] write_data0,
   output logic [DATA_WIDTH-1:0] write_data1,
   output logic [DATA_WIDTH-1:0] write_data2,
   output logic [DATA_WIDTH-1:0] write_data3
);

   logic [3:0][DATA_WIDTH-1:0] cmp_in_data;
   logic [4:0]                 cmp_cnt;
   logic [4:0]                 cmp_start;
   logic [3:0][DATA_WIDTH-1:0] cmp_data;

   logic                       out_vld_q,    out_vld_d;
   logic                       out_thread_q, out_thread_d;
   logic [4:0]                 out_cnt_q,    out_cnt_d;
   logic [4:0]                 out_start_q,  out_start_d;
   logic [3:0][DATA_WIDTH-1:0] out_data_q,   out_data_d;

   logic                       skid_vld_q,    skid_vld_d;
   logic                       skid_thread_q, skid_thread_d;
   logic [4:0]                 skid_cnt_q,    skid_cnt_d;
   logic [4:0]                 skid_start_q,  skid_start_d;
   logic [3:0][DATA_WIDTH-1:0] skid_data_q,   skid_data_d;

   logic consume;
   logic accept;
   logic in_keep;
   logic out_live;
   logic skid_live;

   assign cmp_in_data = {in_data3, in_data2, in_data1, in_data0};

   iqe_compact #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_compact (
      .in_mask (in_mask),
      .in_data (cmp_in_data),
      .cnt     (cmp_cnt),
      .start   (cmp_start),
      .data    (cmp_data)
   );

   // SKID occupancy alone gates input; no path from the stall inputs.
   assign in_rdy = ~skid_vld_q;

   // Handshake and flush qualifiers for this cycle.
   always_comb begin
      consume   = out_vld_q & ~fStall & ~doFStall;
      accept    = in_vld & in_rdy;
      // Zero-count bundles and bundles of the flushed thread are accepted but dropped.
      in_keep   = accept & ~cmp_cnt[0] & ~(except & (in_thread == except_thread));
      out_live  = out_vld_q & ~consume & ~(except & (out_thread_q == except_thread));
      skid_live = skid_vld_q & ~(except & (skid_thread_q == except_thread));
   end

   // Next buffer state: OUT keeps its entry, takes SKID, or takes the input.
   always_comb begin
      out_vld_d     = out_vld_q;
      out_thread_d  = out_thread_q;
      out_cnt_d     = out_cnt_q;
      out_start_d   = out_start_q;
      out_data_d    = out_data_q;
      skid_vld_d    = skid_vld_q;
      skid_thread_d = skid_thread_q;
      skid_cnt_d    = skid_cnt_q;
      skid_start_d  = skid_start_q;
      skid_data_d   = skid_data_q;

      if (out_live) begin
         // OUT held; a surviving SKID stays put (input was blocked by in_rdy).
         if (!skid_live) begin
            skid_vld_d = in_keep;
            if (in_keep) begin
               skid_thread_d = in_thread;
               skid_cnt_d    = cmp_cnt;
               skid_start_d  = cmp_start;
               skid_data_d   = cmp_data;
            end
         end
      end else if (skid_live) begin
         out_vld_d    = 1'b1;
         out_thread_d = skid_thread_q;
         out_cnt_d    = skid_cnt_q;
         out_start_d  = skid_start_q;
         out_data_d   = skid_data_q;
         skid_vld_d   = in_keep;
         if (in_keep) begin
            skid_thread_d = in_thread;
            skid_cnt_d    = cmp_cnt;
            skid_start_d  = cmp_start;
            skid_data_d   = cmp_data;
         end
      end else begin
         out_vld_d  = in_keep;
         skid_vld_d = 1'b0;
         if (in_keep) begin
            out_thread_d = in_thread;
            out_cnt_d    = cmp_cnt;
            out_start_d  = cmp_start;
            out_data_d   = cmp_data;
         end
      end
   end

   // Buffer registers; reset presents an empty zero-count bundle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_vld_q     <= 1'b0;
         out_thread_q  <= 1'b0;
         out_cnt_q     <= 5'b00001;
         out_start_q   <= 5'b10000;
         out_data_q    <= '0;
         skid_vld_q    <= 1'b0;
         skid_thread_q <= 1'b0;
         skid_cnt_q    <= 5'b00001;
         skid_start_q  <= 5'b10000;
         skid_data_q   <= '0;
      end else begin
         out_vld_q     <= out_vld_d;
         out_thread_q  <= out_thread_d;
         out_cnt_q     <= out_cnt_d;
         out_start_q   <= out_start_d;
         out_data_q    <= out_data_d;
         skid_vld_q    <= skid_vld_d;
         skid_thread_q <= skid_thread_d;
         skid_cnt_q    <= skid_cnt_d;
         skid_start_q  <= skid_start_d;
         skid_data_q   <= skid_data_d;
      end
   end

   assign write_wen    = out_vld_q;
   assign write_thread = out_thread_q;
   assign write_cnt    = out_cnt_q;
   assign write_start  = out_start_q;
   assign write_data0  = out_data_q[0];
   assign write_data1  = out_data_q[1];
   assign write_data2  = out_data_q[2];
   assign write_data3  = out_data_q[3];

endmodule

// File: tb/tb_instrq_extra_feed.sv
// Bench for instrq_extra_feed: directed scenarios plus random traffic,
// checked against a queue-based model of the feeder's visible behaviour.

module tb_instrq_extra_feed;

   localparam int DW = instrq_extra_feed_pkg::IQE_DATA_W;

   typedef struct packed {
      logic               thread;
      logic [2:0]         n;
      logic [3:0][DW-1:0] w;
   } bundle_t;

   logic          clk;
   logic          rst;
   logic          except;
   logic          except_thread;
   logic          in_vld;
   logic          in_thread;
   logic [3:0]    in_mask;
   logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
   logic          in_rdy;
   logic          fStall;
   logic          doFStall;
   logic          write_wen;
   logic          write_thread;
   logic [4:0]    write_cnt;
   logic [4:0]    write_start;
   logic [DW-1:0] write_data0, write_data1, write_data2, write_data3;

   int n_checks = 0;
   int n_pass   = 0;

   bundle_t mq[$];

   instrq_extra_feed #(.DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .except        (except),
      .except_thread (except_thread),
      .in_vld        (in_vld),
      .in_thread     (in_thread),
      .in_mask       (in_mask),
      .in_data0      (in_data0),
      .in_data1      (in_data1),
      .in_data2      (in_data2),
      .in_data3      (in_data3),
      .in_rdy        (in_rdy),
      .fStall        (fStall),
      .doFStall      (doFStall),
      .write_wen     (write_wen),
      .write_thread  (write_thread),
      .write_cnt     (write_cnt),
      .write_start   (write_start),
      .write_data0   (write_data0),
      .write_data1   (write_data1),
      .write_data2   (write_data2),
      .write_data3   (write_data3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic logic [3:0][DW-1:0] words4(input logic [DW-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   // Reference compaction: list of valid words, right-justified into slots 0..3.
   function automatic bundle_t compact_ref(input logic thr, input logic [3:0] m,
                                           input logic [3:0][DW-1:0] d);
      logic [DW-1:0] words[$];
      bundle_t b;
      b = '0;
      b.thread = thr;
      for (int i = 0; i < 4; i++) if (m[i]) words.push_back(d[i]);
      b.n = 3'(words.size());
      for (int j = 0; j < words.size(); j++) b.w[2'(4 - words.size() + j)] = words[j];
      return b;
   endfunction

   task automatic check_model();
      chk("wen", 64'(write_wen), 64'(mq.size() != 0));
      chk("rdy", 64'(in_rdy), 64'(mq.size() < 2));
      if (mq.size() != 0) begin
         chk("thread", 64'(write_thread), 64'(mq[0].thread));
         chk("cnt",    64'(write_cnt),    64'(1) << mq[0].n);
         chk("start",  64'(write_start),  64'(16) >> mq[0].n);
         chk("data0",  64'(write_data0),  64'(mq[0].w[0]));
         chk("data1",  64'(write_data1),  64'(mq[0].w[1]));
         chk("data2",  64'(write_data2),  64'(mq[0].w[2]));
         chk("data3",  64'(write_data3),  64'(mq[0].w[3]));
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_wen"},    64'(write_wen),    64'(0));
      chk({tag, "_thread"}, 64'(write_thread), 64'(0));
      chk({tag, "_cnt"},    64'(write_cnt),    64'(5'b00001));
      chk({tag, "_start"},  64'(write_start),  64'(5'b10000));
      chk({tag, "_data"},   64'({write_data3, write_data2, write_data1, write_data0}) , 64'(0));
      chk({tag, "_rdy"},    64'(in_rdy),       64'(1));
   endtask

   task automatic drive_idle();
      in_vld = 1'b0; in_thread = 1'b0; in_mask = 4'b0;
      in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
      fStall = 1'b0; doFStall = 1'b0; except = 1'b0; except_thread = 1'b0;
   endtask

   // Drive one cycle (called just after a falling edge), advance the model,
   // then compare the registered outputs half a cycle after the rising edge.
   task automatic step(input logic v, input logic thr, input logic [3:0] m,
                       input logic [3:0][DW-1:0] d, input logic fs, input logic dfs,
                       input logic ex, input logic exth);
      bit acc;
      bundle_t keep[$];
      in_vld = v; in_thread = thr; in_mask = m;
      in_data0 = d[0]; in_data1 = d[1]; in_data2 = d[2]; in_data3 = d[3];
      fStall = fs; doFStall = dfs; except = ex; except_thread = exth;

      acc = v && (mq.size() < 2);
      if (mq.size() != 0 && !fs && !dfs) void'(mq.pop_front());
      if (ex) begin
         foreach (mq[i]) if (mq[i].thread != exth) keep.push_back(mq[i]);
         mq = keep;
      end
      if (acc && m != 4'b0 && !(ex && thr == exth)) mq.push_back(compact_ref(thr, m, d));

      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   initial begin
      logic [3:0][DW-1:0] nod;
      nod = '0;
      drive_idle();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b1;

      // Sparse mask: slots 1 and 3 land in output slots 2 and 3.
      step(1, 0, 4'b1010, words4('hA0, 'hA1, 'hA2, 'hA3), 0, 0, 0, 0);
      chk("sparse_wen",   64'(write_wen),   64'(1));
      chk("sparse_cnt",   64'(write_cnt),   64'(5'b00100));
      chk("sparse_start", 64'(write_start), 64'(5'b00100));
      chk("sparse_d0",    64'(write_data0), 64'(0));
      chk("sparse_d1",    64'(write_data1), 64'(0));
      chk("sparse_d2",    64'(write_data2), 64'('hA1));
      chk("sparse_d3",    64'(write_data3), 64'('hA3));

      // Full mask keeps order; empty mask never produces a write.
      step(1, 0, 4'b1111, words4('hB0, 'hB1, 'hB2, 'hB3), 0, 0, 0, 0);
      chk("full_cnt",   64'(write_cnt),   64'(5'b10000));
      chk("full_start", 64'(write_start), 64'(5'b00001));
      chk("full_d0",    64'(write_data0), 64'('hB0));
      chk("full_d3",    64'(write_data3), 64'('hB3));
      step(1, 1, 4'b0000, words4('hE0, 'hE1, 'hE2, 'hE3), 0, 0, 0, 0);
      chk("empty_wen", 64'(write_wen), 64'(0));

      // Five cycles of doFStall with back-to-back inputs.
      step(1, 0, 4'b1111, words4('hC0, 'hC1, 'hC2, 'hC3), 0, 1, 0, 0);
      chk("stall_rdy1", 64'(in_rdy), 64'(1));
      step(1, 0, 4'b0011, words4('hD0, 'hD1, 'hD2, 'hD3), 0, 1, 0, 0);
      chk("stall_rdy0", 64'(in_rdy), 64'(0));
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 4'b1111, words4('h70, 'h71, 'h72, 'h73), 0, 1, 0, 0);
         chk("stall_hold_d0", 64'(write_data0), 64'('hC0));
      end
      step(0, 0, 4'b0000, nod, 0, 0, 0, 0);
      chk("drain_d2",  64'(write_data2), 64'('hD0));
      chk("drain_rdy", 64'(in_rdy),      64'(1));
      step(0, 0, 4'b0000, nod, 0, 0, 0, 0);
      chk("drain_wen", 64'(write_wen), 64'(0));

      // Flush thread 0 with OUT=t0, SKID=t1: the t1 bundle is promoted.
      step(1, 0, 4'b1111, words4('h10, 'h11, 'h12, 'h13), 1, 0, 0, 0);
      step(1, 1, 4'b1111, words4('h20, 'h21, 'h22, 'h23), 1, 0, 0, 0);
      step(0, 0, 4'b0000, nod, 1, 0, 1, 0);
      chk("exc0_thread", 64'(write_thread), 64'(1));
      chk("exc0_d0",     64'(write_data0),  64'('h20));
      chk("exc0_rdy",    64'(in_rdy),       64'(1));
      step(0, 0, 4'b0000, nod, 0, 0, 0, 0);

      // Flush thread 1 instead: the t0 OUT entry survives.
      step(1, 0, 4'b1111, words4('h30, 'h31, 'h32, 'h33), 1, 0, 0, 0);
      step(1, 1, 4'b1111, words4('h40, 'h41, 'h42, 'h43), 1, 0, 0, 0);
      step(0, 0, 4'b0000, nod, 1, 0, 1, 1);
      chk("exc1_thread", 64'(write_thread), 64'(0));
      chk("exc1_d0",     64'(write_data0),  64'('h30));
      chk("exc1_rdy",    64'(in_rdy),       64'(1));
      step(0, 0, 4'b0000, nod, 0, 0, 0, 0);

      // Same-thread input during a flush is dropped.
      step(1, 1, 4'b1111, words4('h50, 'h51, 'h52, 'h53), 0, 0, 1, 1);
      chk("excin_wen", 64'(write_wen), 64'(0));

      // Asynchronous reset with both entries full, mid-stall.
      step(1, 0, 4'b0111, words4('h60, 'h61, 'h62, 'h63), 1, 0, 0, 0);
      step(1, 1, 4'b1000, words4('h64, 'h65, 'h66, 'h67), 1, 0, 0, 0);
      chk("prerst_rdy", 64'(in_rdy), 64'(0));
      drive_idle();
      fStall = 1'b1;
      rst = 1'b0;
      #2;
      check_reset("async_rst");
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      fStall = 1'b0;
      step(0, 0, 4'b0000, nod, 0, 0, 0, 0);
      chk("postrst_wen", 64'(write_wen), 64'(0));

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
              words4($urandom, $urandom, $urandom, $urandom),
              $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0, 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
